// File: rtl/flash_job_seq.sv
// Job sequencer in front of flash_b: one sector erase covering the job,
// then one single-page write per full page available in the input FIFO.
module flash_job_seq #(
   parameter int unsigned PAGE_BYTES     = 256,
   parameter int unsigned SECTOR_BYTES   = 65536,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        job_start,
   input  logic [31:0] job_addr,
   input  logic [31:0] job_len,
   input  logic        job_abort,
   input  logic [15:0] fifo_bytes,
   input  logic        flash_done,
   output logic        cmd_erasesectors,
   output logic        cmd_write,
   output logic [31:0] cmd_addr,
   output logic [31:0] cmd_length,
   output logic        job_busy,
   output logic        job_done,
   output logic        job_error,
   output logic [2:0]  err_code,
   output logic [23:0] pages_done
);

   localparam int unsigned PAGE_SH = $clog2(PAGE_BYTES);
   localparam int unsigned SEC_SH  = $clog2(SECTOR_BYTES);
   localparam logic [31:0] PAGE_MASK = 32'(PAGE_BYTES - 1);
   localparam logic [31:0] SEC_MASK  = 32'(SECTOR_BYTES - 1);
   localparam logic [31:0] PAGE_INC  = 32'(PAGE_BYTES);
   localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] E_NONE    = 3'd0;
   localparam logic [2:0] E_ALIGN   = 3'd1;
   localparam logic [2:0] E_ZERO    = 3'd2;
   localparam logic [2:0] E_TIMEOUT = 3'd3;
   localparam logic [2:0] E_ABORT   = 3'd4;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CHECK,
      S_ERASE_ISSUE,
      S_ERASE_WAIT,
      S_WAIT_DATA,
      S_WRITE_ISSUE,
      S_WRITE_WAIT,
      S_DONE,
      S_FAIL
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] len_q, len_d;
   logic [31:0] pages_q, pages_d;
   logic [31:0] page_addr_q, page_addr_d;
   logic [31:0] wdog_q, wdog_d;
   logic [23:0] pages_done_q, pages_done_d;
   logic [2:0]  code_q, code_d;
   logic        error_q, error_d;
   logic [31:0] cmd_addr_q, cmd_addr_d;
   logic [31:0] cmd_len_q, cmd_len_d;
   logic        erase_q, erase_d;
   logic        write_q, write_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [31:0] sectors;
   logic [31:0] pages;
   logic        fifo_full_page;
   logic        last_page;

   assign sectors = (len_q >> SEC_SH)
                  + {31'b0, |(len_q & SEC_MASK)};
   assign pages   = (len_q >> PAGE_SH)
                  + {31'b0, |(len_q & PAGE_MASK)};
   assign fifo_full_page = ({16'b0, fifo_bytes} >= PAGE_INC);
   assign last_page = (({8'b0, pages_done_q} + 32'd1) == pages_q);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      len_d        = len_q;
      pages_d      = pages_q;
      page_addr_d  = page_addr_q;
      wdog_d       = wdog_q;
      pages_done_d = pages_done_q;
      code_d       = code_q;
      error_d      = error_q;
      cmd_addr_d   = cmd_addr_q;
      cmd_len_d    = cmd_len_q;
      unique case (state_q)
         S_IDLE: begin
            if (job_start) begin
               addr_d       = job_addr;
               len_d        = job_len;
               code_d       = E_NONE;
               error_d      = 1'b0;
               pages_done_d = '0;
               state_d      = S_CHECK;
            end
         end
         S_CHECK: begin
            if ((addr_q & SEC_MASK) != '0) begin
               code_d  = E_ALIGN;
               error_d = 1'b1;
               state_d = S_FAIL;
            end else if (len_q == '0) begin
               code_d  = E_ZERO;
               error_d = 1'b1;
               state_d = S_FAIL;
            end else begin
               pages_d    = pages;
               cmd_addr_d = addr_q;
               cmd_len_d  = sectors;
               state_d    = S_ERASE_ISSUE;
            end
         end
         S_ERASE_ISSUE: begin
            wdog_d  = '0;
            state_d = S_ERASE_WAIT;
         end
         S_ERASE_WAIT: begin
            // A done on the watchdog's last cycle still counts as success.
            if (flash_done) begin
               page_addr_d = addr_q;
               state_d     = S_WAIT_DATA;
            end else if (wdog_q == WDOG_LAST) begin
               code_d  = E_TIMEOUT;
               error_d = 1'b1;
               state_d = S_FAIL;
            end else begin
               wdog_d = wdog_q + 32'd1;
            end
         end
         S_WAIT_DATA: begin
            if (job_abort) begin
               code_d  = E_ABORT;
               error_d = 1'b1;
               state_d = S_FAIL;
            end else if (fifo_full_page) begin
               cmd_addr_d = page_addr_q;
               cmd_len_d  = 32'd1;
               state_d    = S_WRITE_ISSUE;
            end
         end
         S_WRITE_ISSUE: begin
            wdog_d  = '0;
            state_d = S_WRITE_WAIT;
         end
         S_WRITE_WAIT: begin
            if (flash_done) begin
               pages_done_d = pages_done_q + 24'd1;
               page_addr_d  = page_addr_q + PAGE_INC;
               state_d      = last_page ? S_DONE : S_WAIT_DATA;
            end else if (wdog_q == WDOG_LAST) begin
               code_d  = E_TIMEOUT;
               error_d = 1'b1;
               state_d = S_FAIL;
            end else begin
               wdog_d = wdog_q + 32'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_FAIL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      erase_d = (state_d == S_ERASE_ISSUE);
      write_d = (state_d == S_WRITE_ISSUE);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE) || (state_d == S_FAIL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         len_q        <= '0;
         pages_q      <= '0;
         page_addr_q  <= '0;
         wdog_q       <= '0;
         pages_done_q <= '0;
         code_q       <= '0;
         error_q      <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_len_q    <= '0;
         erase_q      <= 1'b0;
         write_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         pages_q      <= pages_d;
         page_addr_q  <= page_addr_d;
         wdog_q       <= wdog_d;
         pages_done_q <= pages_done_d;
         code_q       <= code_d;
         error_q      <= error_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_len_q    <= cmd_len_d;
         erase_q      <= erase_d;
         write_q      <= write_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign cmd_erasesectors = erase_q;
   assign cmd_write        = write_q;
   assign cmd_addr         = cmd_addr_q;
   assign cmd_length       = cmd_len_q;
   assign job_busy         = busy_q;
   assign job_done         = done_q;
   assign job_error        = error_q;
   assign err_code         = code_q;
   assign pages_done       = pages_done_q;

endmodule

// File: tb/tb_flash_job_seq.sv
// Bench for flash_job_seq: directed jobs plus a timeline model of the
// job flow compared against every output on every cycle.
module tb_flash_job_seq;

   localparam int PAGE = 256;
   localparam int SECT = 65536;
   localparam int TMO  = 100;

   logic        clk;
   logic        reset;
   logic        job_start;
   logic [31:0] job_addr;
   logic [31:0] job_len;
   logic        job_abort;
   logic [15:0] fifo_bytes;
   logic        flash_done;
   logic        cmd_erasesectors;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_length;
   logic        job_busy;
   logic        job_done;
   logic        job_error;
   logic [2:0]  err_code;
   logic [23:0] pages_done;

   flash_job_seq #(
      .PAGE_BYTES(PAGE),
      .SECTOR_BYTES(SECT),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .job_start(job_start),
      .job_addr(job_addr),
      .job_len(job_len),
      .job_abort(job_abort),
      .fifo_bytes(fifo_bytes),
      .flash_done(flash_done),
      .cmd_erasesectors(cmd_erasesectors),
      .cmd_write(cmd_write),
      .cmd_addr(cmd_addr),
      .cmd_length(cmd_length),
      .job_busy(job_busy),
      .job_done(job_done),
      .job_error(job_error),
      .err_code(err_code),
      .pages_done(pages_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   bit          m_valid = 1'b0;
   bit          m_erase, m_write, m_busy, m_done, m_err;
   logic [31:0] m_addr, m_len;
   logic [23:0] m_pages;
   logic [2:0]  m_code;
   bit          s_start, s_abort, s_done;
   logic [31:0] s_addr, s_len;
   logic [15:0] s_fifo;

   // Advance one clock: sample inputs, drop one-cycle pulses, apply reset.
   task automatic mstep(output bit r);
      @(posedge clk);
      s_start = job_start;
      s_addr  = job_addr;
      s_len   = job_len;
      s_abort = job_abort;
      s_done  = flash_done;
      s_fifo  = fifo_bytes;
      m_erase = 1'b0;
      m_write = 1'b0;
      m_done  = 1'b0;
      r = reset;
      if (r) begin
         m_busy  = 1'b0;
         m_err   = 1'b0;
         m_addr  = '0;
         m_len   = '0;
         m_pages = '0;
         m_code  = '0;
      end
   endtask

   task automatic finish_job(input logic [2:0] code);
      bit r;
      m_done = 1'b1;
      if (code != 3'd0) begin
         m_err  = 1'b1;
         m_code = code;
      end
      mstep(r);
      if (!r) m_busy = 1'b0;
   endtask

   // Up to TMO wait cycles; a done in any of them succeeds.
   task automatic wait_flash(output bit ok, output bit r);
      ok = 1'b0;
      r  = 1'b0;
      for (int n = 0; n < TMO; n++) begin
         mstep(r);
         if (r) return;
         if (s_done) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic model_job(input logic [31:0] a, input logic [31:0] l);
      bit r, ok;
      longint sec, pg;
      logic [31:0] pa;
      m_busy  = 1'b1;
      m_err   = 1'b0;
      m_code  = '0;
      m_pages = '0;
      mstep(r);
      if (r) return;
      if (a % SECT != 0) begin finish_job(3'd1); return; end
      if (l == 0) begin finish_job(3'd2); return; end
      sec = (longint'(l) + SECT - 1) / SECT;
      pg  = (longint'(l) + PAGE - 1) / PAGE;
      m_erase = 1'b1;
      m_addr  = a;
      m_len   = 32'(sec);
      mstep(r);
      if (r) return;
      wait_flash(ok, r);
      if (r) return;
      if (!ok) begin finish_job(3'd3); return; end
      pa = a;
      for (longint p = 0; p < pg; p++) begin
         while (1) begin
            mstep(r);
            if (r) return;
            if (s_abort) begin finish_job(3'd4); return; end
            if (s_fifo >= 16'(PAGE)) break;
         end
         m_write = 1'b1;
         m_addr  = pa;
         m_len   = 32'd1;
         mstep(r);
         if (r) return;
         wait_flash(ok, r);
         if (r) return;
         if (!ok) begin finish_job(3'd3); return; end
         m_pages = m_pages + 24'd1;
         pa = pa + 32'(PAGE);
      end
      finish_job(3'd0);
   endtask

   initial begin : model
      bit r;
      forever begin
         mstep(r);
         m_valid = 1'b1;
         if (!r && s_start) model_job(s_addr, s_len);
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("cmp_erase", 64'(cmd_erasesectors), 64'(m_erase));
         chk("cmp_write", 64'(cmd_write), 64'(m_write));
         chk("cmp_addr", 64'(cmd_addr), 64'(m_addr));
         chk("cmp_len", 64'(cmd_length), 64'(m_len));
         chk("cmp_busy", 64'(job_busy), 64'(m_busy));
         chk("cmp_done", 64'(job_done), 64'(m_done));
         chk("cmp_error", 64'(job_error), 64'(m_err));
         chk("cmp_code", 64'(err_code), 64'(m_code));
         chk("cmp_pages", 64'(pages_done), 64'(m_pages));
      end
   end

   // ---------------- stimulus ----------------
   int n_erase = 0;
   int n_write = 0;
   int n_done = 0;
   always @(posedge clk) begin
      if (cmd_erasesectors === 1'b1) n_erase++;
      if (cmd_write === 1'b1) n_write++;
      if (job_done === 1'b1) n_done++;
   end

   function automatic logic sig(input int sel);
      case (sel)
         0:       return cmd_erasesectors;
         1:       return cmd_write;
         default: return job_done;
      endcase
   endfunction

   task automatic wait_pulse(input int sel, input int max,
                             input string name, output int n);
      n = 0;
      while (sig(sel) !== 1'b1 && n < max) begin
         @(negedge clk);
         n++;
      end
      if (sig(sel) !== 1'b1) chk({name, "_seen"}, 64'(sig(sel)), 64'd1);
   endtask

   task automatic start_job(input logic [31:0] a, input logic [31:0] l);
      @(negedge clk);
      job_start = 1'b1;
      job_addr  = a;
      job_len   = l;
      @(negedge clk);
      job_start = 1'b0;
   endtask

   task automatic pulse_done();
      flash_done = 1'b1;
      @(negedge clk);
      flash_done = 1'b0;
   endtask

   initial begin : stim
      int n, e0, w0, d0;
      reset = 1'b1;
      job_start = 1'b0;
      job_addr = '0;
      job_len = '0;
      job_abort = 1'b0;
      fifo_bytes = '0;
      flash_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(job_busy), 64'd0);
      chk("rst_addr", 64'(cmd_addr), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // happy path: 600 bytes -> 1 sector, 3 pages
      fifo_bytes = 16'd1024;
      start_job(32'h0001_0000, 32'd600);
      wait_pulse(0, 10, "happy_erase", n);
      chk("happy_erase_lat", 64'(n), 64'd1);
      chk("happy_erase_addr", 64'(cmd_addr), 64'h10000);
      chk("happy_erase_len", 64'(cmd_length), 64'd1);
      @(negedge clk);
      job_start = 1'b1;
      job_addr = 32'h0;
      job_len = 32'd256;
      @(negedge clk);
      job_start = 1'b0;
      repeat (3) @(negedge clk);
      pulse_done();
      for (int i = 0; i < 3; i++) begin
         wait_pulse(1, 10, "happy_write", n);
         chk("happy_write_lat", 64'(n), 64'd1);
         chk("happy_write_addr", 64'(cmd_addr), 64'h10000 + 64'(i) * 256);
         chk("happy_write_len", 64'(cmd_length), 64'd1);
         repeat (2) @(negedge clk);
         pulse_done();
      end
      chk("happy_done", 64'(job_done), 64'd1);
      chk("happy_pages", 64'(pages_done), 64'd3);
      chk("happy_error", 64'(job_error), 64'd0);
      @(negedge clk);
      chk("happy_n_erase", 64'(n_erase), 64'd1);
      chk("happy_n_write", 64'(n_write), 64'd3);

      // misaligned address
      e0 = n_erase;
      w0 = n_write;
      start_job(32'h0000_0100, 32'd600);
      wait_pulse(2, 10, "align_done", n);
      chk("align_lat", 64'(n), 64'd1);
      chk("align_code", 64'(err_code), 64'd1);
      chk("align_error", 64'(job_error), 64'd1);

      // zero length
      start_job(32'h0, 32'd0);
      wait_pulse(2, 10, "zero_done", n);
      chk("zero_lat", 64'(n), 64'd1);
      chk("zero_code", 64'(err_code), 64'd2);
      repeat (2) @(negedge clk);
      chk("bad_no_erase", 64'(n_erase - e0), 64'd0);
      chk("bad_no_write", 64'(n_write - w0), 64'd0);

      // FIFO starvation, with a stray done in WAIT_DATA
      fifo_bytes = 16'd255;
      start_job(32'h0002_0000, 32'd256);
      wait_pulse(0, 10, "starve_erase", n);
      repeat (2) @(negedge clk);
      pulse_done();
      w0 = n_write;
      repeat (500) @(negedge clk);
      pulse_done();
      repeat (498) @(negedge clk);
      chk("starve_no_write", 64'(n_write - w0), 64'd0);
      fifo_bytes = 16'd256;
      wait_pulse(1, 10, "starve_write", n);
      chk("starve_write_lat", 64'(n), 64'd1);
      chk("starve_write_addr", 64'(cmd_addr), 64'h20000);
      repeat (2) @(negedge clk);
      pulse_done();
      chk("starve_done", 64'(job_done), 64'd1);
      chk("starve_pages", 64'(pages_done), 64'd1);
      @(negedge clk);
      chk("starve_one_write", 64'(n_write - w0), 64'd1);

      // erase timeout
      fifo_bytes = 16'd0;
      start_job(32'h0003_0000, 32'd256);
      wait_pulse(0, 10, "tmo_erase", n);
      wait_pulse(2, 300, "tmo_done", n);
      chk("tmo_lat", 64'(n), 64'd101);
      chk("tmo_code", 64'(err_code), 64'd3);
      chk("tmo_error", 64'(job_error), 64'd1);

      // done on the last watchdog cycle wins
      fifo_bytes = 16'd1024;
      start_job(32'h0004_0000, 32'd256);
      wait_pulse(0, 10, "term_erase", n);
      repeat (100) @(negedge clk);
      pulse_done();
      wait_pulse(1, 10, "term_write", n);
      chk("term_write_lat", 64'(n), 64'd1);
      chk("term_write_addr", 64'(cmd_addr), 64'h40000);
      repeat (2) @(negedge clk);
      pulse_done();
      chk("term_done", 64'(job_done), 64'd1);
      chk("term_error", 64'(job_error), 64'd0);

      // abort raised during WRITE_WAIT
      start_job(32'h0005_0000, 32'd512);
      wait_pulse(0, 10, "abww_erase", n);
      repeat (2) @(negedge clk);
      pulse_done();
      wait_pulse(1, 10, "abww_write", n);
      @(negedge clk);
      job_abort = 1'b1;
      repeat (2) @(negedge clk);
      pulse_done();
      chk("abww_pages", 64'(pages_done), 64'd1);
      wait_pulse(2, 10, "abww_done", n);
      chk("abww_lat", 64'(n), 64'd1);
      chk("abww_code", 64'(err_code), 64'd4);
      job_abort = 1'b0;

      // abort in WAIT_DATA
      fifo_bytes = 16'd0;
      start_job(32'h0006_0000, 32'd512);
      wait_pulse(0, 10, "abwd_erase", n);
      repeat (2) @(negedge clk);
      pulse_done();
      repeat (5) @(negedge clk);
      job_abort = 1'b1;
      wait_pulse(2, 10, "abwd_done", n);
      chk("abwd_lat", 64'(n), 64'd1);
      chk("abwd_code", 64'(err_code), 64'd4);
      chk("abwd_pages", 64'(pages_done), 64'd0);
      job_abort = 1'b0;

      // reset in WRITE_WAIT, then a late flash_done
      fifo_bytes = 16'd1024;
      start_job(32'h0007_0000, 32'd512);
      wait_pulse(0, 10, "rst_erase", n);
      repeat (2) @(negedge clk);
      pulse_done();
      wait_pulse(1, 10, "rst_write", n);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      d0 = n_done;
      pulse_done();
      repeat (20) @(negedge clk);
      chk("rst_no_done", 64'(n_done - d0), 64'd0);
      chk("rst_cmd_addr", 64'(cmd_addr), 64'd0);
      chk("rst_cmd_len", 64'(cmd_length), 64'd0);
      chk("rst_job_busy", 64'(job_busy), 64'd0);

      // fresh job after reset
      start_job(32'h0001_0000, 32'd256);
      wait_pulse(0, 10, "post_erase", n);
      chk("post_erase_lat", 64'(n), 64'd1);
      repeat (2) @(negedge clk);
      pulse_done();
      wait_pulse(1, 10, "post_write", n);
      chk("post_write_addr", 64'(cmd_addr), 64'h10000);
      repeat (2) @(negedge clk);
      pulse_done();
      chk("post_done", 64'(job_done), 64'd1);
      chk("post_error", 64'(job_error), 64'd0);
      chk("post_pages", 64'(pages_done), 64'd1);

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
